// File: rtl/hpdcache_refill_sequencer.sv
// ---------------------------------------------------------------------------
// hpdcache_refill_sequencer
//
// Purpose:
//   Consumer end of the cache miss path. Takes multi-beat refill responses
//   from memory, acknowledges the owning MSHR entry, captures the entry
//   fields returned one cycle after the ack, streams the beats into the
//   cache data array and finally returns the core response for the pending
//   load (with its error flag). Prefetches and entries without need_rsp get
//   no core response.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   mem_rsp_*               refill beat stream from memory (valid/ready)
//   mshr_ack_*              ack request to the MSHR (held until grant)
//   mshr_*_i                MSHR entry fields, valid the cycle after the ack
//   refill_*                data-array write port plus line-done pulse
//   core_rsp_*              response to the core (valid/ready)
// ---------------------------------------------------------------------------
module hpdcache_refill_sequencer #(
  parameter int MSHR_SET_WIDTH = 3,
  parameter int MSHR_WAY_WIDTH = 2,
  parameter int SET_WIDTH      = 7,
  parameter int TAG_WIDTH      = 20,
  parameter int WAY_WIDTH      = 2,
  parameter int WORD_WIDTH     = 3,
  parameter int WORD_BITS      = 64,
  parameter int BEAT_WORDS     = 2,
  parameter int BEATS          = 4,
  parameter int REQ_ID_WIDTH   = 8,
  parameter int SRC_ID_WIDTH   = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,

  input  logic                                 mem_rsp_valid_i,
  output logic                                 mem_rsp_ready_o,
  input  logic [MSHR_WAY_WIDTH+MSHR_SET_WIDTH-1:0] mem_rsp_id_i,
  input  logic [BEAT_WORDS*WORD_BITS-1:0]      mem_rsp_data_i,
  input  logic                                 mem_rsp_error_i,
  input  logic                                 mem_rsp_last_i,

  output logic                                 mshr_ack_o,
  input  logic                                 mshr_ack_gnt_i,
  output logic [MSHR_SET_WIDTH-1:0]            mshr_ack_set_o,
  output logic [MSHR_WAY_WIDTH-1:0]            mshr_ack_way_o,
  input  logic [REQ_ID_WIDTH-1:0]              mshr_req_id_i,
  input  logic [SRC_ID_WIDTH-1:0]              mshr_src_id_i,
  input  logic [SET_WIDTH-1:0]                 mshr_cache_set_i,
  input  logic [WAY_WIDTH-1:0]                 mshr_cache_way_i,
  input  logic [TAG_WIDTH-1:0]                 mshr_cache_tag_i,
  input  logic [WORD_WIDTH-1:0]                mshr_word_i,
  input  logic                                 mshr_need_rsp_i,
  input  logic                                 mshr_is_prefetch_i,
  input  logic                                 mshr_wback_i,

  output logic                                 refill_write_o,
  input  logic                                 refill_ready_i,
  output logic [SET_WIDTH-1:0]                 refill_set_o,
  output logic [WAY_WIDTH-1:0]                 refill_way_o,
  output logic [$clog2(BEATS)-1:0]             refill_beat_o,
  output logic [BEAT_WORDS*WORD_BITS-1:0]      refill_data_o,
  output logic                                 refill_done_o,
  output logic [TAG_WIDTH-1:0]                 refill_tag_o,
  output logic                                 refill_wback_o,

  output logic                                 core_rsp_valid_o,
  input  logic                                 core_rsp_ready_i,
  output logic [REQ_ID_WIDTH-1:0]              core_rsp_req_id_o,
  output logic [SRC_ID_WIDTH-1:0]              core_rsp_src_id_o,
  output logic [WORD_BITS-1:0]                 core_rsp_data_o,
  output logic                                 core_rsp_error_o
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int SLOT_W = $clog2(BEAT_WORDS);
  localparam int ID_W   = MSHR_WAY_WIDTH + MSHR_SET_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    CAPT,
    WRITE,
    RSP
  } state_e;

  state_e                    state_q, state_d;
  logic [MSHR_SET_WIDTH-1:0] mshr_set_q, mshr_set_d;
  logic [MSHR_WAY_WIDTH-1:0] mshr_way_q, mshr_way_d;
  logic [REQ_ID_WIDTH-1:0]   req_id_q, req_id_d;
  logic [SRC_ID_WIDTH-1:0]   src_id_q, src_id_d;
  logic [SET_WIDTH-1:0]      cache_set_q, cache_set_d;
  logic [WAY_WIDTH-1:0]      cache_way_q, cache_way_d;
  logic [TAG_WIDTH-1:0]      tag_q, tag_d;
  logic [WORD_WIDTH-1:0]     word_q, word_d;
  logic                      need_rsp_q, need_rsp_d;
  logic                      is_prefetch_q, is_prefetch_d;
  logic                      wback_q, wback_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic                      err_q, err_d;
  logic [WORD_BITS-1:0]      rsp_data_q, rsp_data_d;

  logic                      drain;
  logic [WORD_BITS-1:0]      beat_word;

  // Word of the current beat that the pending load asked for.
  assign beat_word = mem_rsp_data_i[int'(word_q[SLOT_W-1:0])*WORD_BITS +: WORD_BITS];

  // Next-state and handshake logic.
  always_comb begin
    state_d         = state_q;
    mshr_set_d      = mshr_set_q;
    mshr_way_d      = mshr_way_q;
    req_id_d        = req_id_q;
    src_id_d        = src_id_q;
    cache_set_d     = cache_set_q;
    cache_way_d     = cache_way_q;
    tag_d           = tag_q;
    word_d          = word_q;
    need_rsp_d      = need_rsp_q;
    is_prefetch_d   = is_prefetch_q;
    wback_d         = wback_q;
    beat_d          = beat_q;
    err_d           = err_q;
    rsp_data_d      = rsp_data_q;
    drain           = 1'b0;
    mem_rsp_ready_o  = 1'b0;
    mshr_ack_o       = 1'b0;
    refill_write_o   = 1'b0;
    refill_done_o    = 1'b0;
    core_rsp_valid_o = 1'b0;

    case (state_q)
      // The first beat only announces the line; it stays in place until WRITE.
      IDLE: begin
        if (mem_rsp_valid_i) begin
          mshr_set_d = mem_rsp_id_i[MSHR_SET_WIDTH-1:0];
          mshr_way_d = mem_rsp_id_i[ID_W-1:MSHR_SET_WIDTH];
          state_d    = ACK;
        end
      end

      ACK: begin
        mshr_ack_o = 1'b1;
        if (mshr_ack_gnt_i) state_d = CAPT;
      end

      // MSHR read data is valid exactly one cycle after the granted ack.
      CAPT: begin
        req_id_d      = mshr_req_id_i;
        src_id_d      = mshr_src_id_i;
        cache_set_d   = mshr_cache_set_i;
        cache_way_d   = mshr_cache_way_i;
        tag_d         = mshr_cache_tag_i;
        word_d        = mshr_word_i;
        need_rsp_d    = mshr_need_rsp_i;
        is_prefetch_d = mshr_is_prefetch_i;
        wback_d       = mshr_wback_i;
        beat_d        = '0;
        err_d         = 1'b0;
        state_d       = WRITE;
      end

      // A beat carrying an error, and every beat after it, is drained
      // without touching the data array.
      WRITE: begin
        drain           = err_q | mem_rsp_error_i;
        refill_write_o  = mem_rsp_valid_i & ~drain;
        mem_rsp_ready_o = drain | refill_ready_i;
        if (mem_rsp_valid_i && mem_rsp_ready_o) begin
          beat_d = beat_q + 1'b1;
          if (mem_rsp_error_i) err_d = 1'b1;
          if (WORD_WIDTH'(beat_q) == (word_q >> SLOT_W)) rsp_data_d = beat_word;
          if (mem_rsp_last_i) begin
            if (beat_q != BEAT_W'(BEATS - 1)) err_d = 1'b1;
            else if (!drain) refill_done_o = 1'b1;
            state_d = (need_rsp_q && !is_prefetch_q) ? RSP : IDLE;
          end
        end
      end

      RSP: begin
        core_rsp_valid_o = 1'b1;
        if (core_rsp_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      mshr_set_q    <= '0;
      mshr_way_q    <= '0;
      req_id_q      <= '0;
      src_id_q      <= '0;
      cache_set_q   <= '0;
      cache_way_q   <= '0;
      tag_q         <= '0;
      word_q        <= '0;
      need_rsp_q    <= 1'b0;
      is_prefetch_q <= 1'b0;
      wback_q       <= 1'b0;
      beat_q        <= '0;
      err_q         <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      mshr_set_q    <= mshr_set_d;
      mshr_way_q    <= mshr_way_d;
      req_id_q      <= req_id_d;
      src_id_q      <= src_id_d;
      cache_set_q   <= cache_set_d;
      cache_way_q   <= cache_way_d;
      tag_q         <= tag_d;
      word_q        <= word_d;
      need_rsp_q    <= need_rsp_d;
      is_prefetch_q <= is_prefetch_d;
      wback_q       <= wback_d;
      beat_q        <= beat_d;
      err_q         <= err_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign mshr_ack_set_o    = mshr_set_q;
  assign mshr_ack_way_o    = mshr_way_q;
  assign refill_set_o      = cache_set_q;
  assign refill_way_o      = cache_way_q;
  assign refill_beat_o     = beat_q;
  assign refill_data_o     = (state_q == WRITE) ? mem_rsp_data_i : '0;
  assign refill_tag_o      = tag_q;
  assign refill_wback_o    = wback_q;
  assign core_rsp_req_id_o = req_id_q;
  assign core_rsp_src_id_o = src_id_q;
  assign core_rsp_data_o   = rsp_data_q;
  assign core_rsp_error_o  = err_q;

endmodule

// File: tb/tb_hpdcache_refill_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hpdcache_refill_sequencer
//
// Directed bench for the refill sequencer. A line task plays the memory,
// MSHR arbiter and MSHR read port cycle by cycle, records what the DUT did
// (acks, writes, done pulses, responses) and the main sequence compares
// those records against hand-computed values.
// Beat b carries word0 = 16*b and word1 = 16*b+1, so the requested word
// index w maps to the value 16*(w/2) + (w%2).
// ---------------------------------------------------------------------------
module tb_hpdcache_refill_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_rsp_valid_i;
  logic         mem_rsp_ready_o;
  logic [4:0]   mem_rsp_id_i;
  logic [127:0] mem_rsp_data_i;
  logic         mem_rsp_error_i;
  logic         mem_rsp_last_i;
  logic         mshr_ack_o;
  logic         mshr_ack_gnt_i;
  logic [2:0]   mshr_ack_set_o;
  logic [1:0]   mshr_ack_way_o;
  logic [7:0]   mshr_req_id_i;
  logic [2:0]   mshr_src_id_i;
  logic [6:0]   mshr_cache_set_i;
  logic [1:0]   mshr_cache_way_i;
  logic [19:0]  mshr_cache_tag_i;
  logic [2:0]   mshr_word_i;
  logic         mshr_need_rsp_i;
  logic         mshr_is_prefetch_i;
  logic         mshr_wback_i;
  logic         refill_write_o;
  logic         refill_ready_i;
  logic [6:0]   refill_set_o;
  logic [1:0]   refill_way_o;
  logic [1:0]   refill_beat_o;
  logic [127:0] refill_data_o;
  logic         refill_done_o;
  logic [19:0]  refill_tag_o;
  logic         refill_wback_o;
  logic         core_rsp_valid_o;
  logic         core_rsp_ready_i;
  logic [7:0]   core_rsp_req_id_o;
  logic [2:0]   core_rsp_src_id_o;
  logic [63:0]  core_rsp_data_o;
  logic         core_rsp_error_o;

  int checks = 0;
  int bad    = 0;

  // Per-line observations filled by applyStimulus.
  int          ackCycles, writes, dones, rspCount, seqBad, badReady, ackAddrBad, tagBad;
  logic        rspErr, finished;
  logic [63:0] rspData;
  logic [10:0] rspIds;

  hpdcache_refill_sequencer dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .mem_rsp_valid_i    (mem_rsp_valid_i),
    .mem_rsp_ready_o    (mem_rsp_ready_o),
    .mem_rsp_id_i       (mem_rsp_id_i),
    .mem_rsp_data_i     (mem_rsp_data_i),
    .mem_rsp_error_i    (mem_rsp_error_i),
    .mem_rsp_last_i     (mem_rsp_last_i),
    .mshr_ack_o         (mshr_ack_o),
    .mshr_ack_gnt_i     (mshr_ack_gnt_i),
    .mshr_ack_set_o     (mshr_ack_set_o),
    .mshr_ack_way_o     (mshr_ack_way_o),
    .mshr_req_id_i      (mshr_req_id_i),
    .mshr_src_id_i      (mshr_src_id_i),
    .mshr_cache_set_i   (mshr_cache_set_i),
    .mshr_cache_way_i   (mshr_cache_way_i),
    .mshr_cache_tag_i   (mshr_cache_tag_i),
    .mshr_word_i        (mshr_word_i),
    .mshr_need_rsp_i    (mshr_need_rsp_i),
    .mshr_is_prefetch_i (mshr_is_prefetch_i),
    .mshr_wback_i       (mshr_wback_i),
    .refill_write_o     (refill_write_o),
    .refill_ready_i     (refill_ready_i),
    .refill_set_o       (refill_set_o),
    .refill_way_o       (refill_way_o),
    .refill_beat_o      (refill_beat_o),
    .refill_data_o      (refill_data_o),
    .refill_done_o      (refill_done_o),
    .refill_tag_o       (refill_tag_o),
    .refill_wback_o     (refill_wback_o),
    .core_rsp_valid_o   (core_rsp_valid_o),
    .core_rsp_ready_i   (core_rsp_ready_i),
    .core_rsp_req_id_o  (core_rsp_req_id_o),
    .core_rsp_src_id_o  (core_rsp_src_id_o),
    .core_rsp_data_o    (core_rsp_data_o),
    .core_rsp_error_o   (core_rsp_error_o)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives the MSHR read port with either the real entry or junk, so a
  // capture in the wrong cycle shows up as wrong tag/ids/word.
  task automatic driveMshr(input logic real_q, input logic needRsp, input logic prefetch,
                           input logic [2:0] word);
    if (real_q) begin
      mshr_req_id_i      = 8'h5A;
      mshr_src_id_i      = 3'd6;
      mshr_cache_set_i   = 7'h2A;
      mshr_cache_way_i   = 2'd3;
      mshr_cache_tag_i   = 20'hABCDE;
      mshr_word_i        = word;
      mshr_need_rsp_i    = needRsp;
      mshr_is_prefetch_i = prefetch;
      mshr_wback_i       = 1'b1;
    end else begin
      mshr_req_id_i      = 8'hA5;
      mshr_src_id_i      = 3'd1;
      mshr_cache_set_i   = 7'h55;
      mshr_cache_way_i   = 2'd0;
      mshr_cache_tag_i   = 20'h12345;
      mshr_word_i        = ~word;
      mshr_need_rsp_i    = ~needRsp;
      mshr_is_prefetch_i = ~prefetch;
      mshr_wback_i       = 1'b0;
    end
  endtask

  // Plays one refill line of 4 beats for MSHR id {way 1, set 5}.
  //   gdelay  : grant withheld for this many ack cycles
  //   toggle  : refill_ready_i alternates 1,0,1,0...
  //   errBeat : beat index carrying mem_rsp_error_i (-1 for none)
  //   abortAt : leave the task once this many beats were accepted (-1 never)
  task automatic applyStimulus(input int gdelay, input bit toggle, input int errBeat,
                               input int abortAt, input logic needRsp, input logic prefetch,
                               input logic [2:0] word);
    int b = 0, post = 0, cyc = 0, ackSeen = 0;
    logic capNext = 1'b0;
    logic [127:0] beatData;
    ackCycles = 0; writes = 0; dones = 0; rspCount = 0; seqBad = 0;
    badReady = 0; ackAddrBad = 0; tagBad = 0; rspErr = 1'b0; rspData = '0;
    rspIds = '0; finished = 1'b0;
    while (!finished && cyc < 60) begin
      beatData          = {64'(16 * b + 1), 64'(16 * b)};
      mem_rsp_valid_i   = (b < 4);
      mem_rsp_id_i      = {2'd1, 3'd5};
      mem_rsp_data_i    = beatData;
      mem_rsp_error_i   = (b == errBeat);
      mem_rsp_last_i    = (b == 3);
      mshr_ack_gnt_i    = (ackSeen >= gdelay);
      refill_ready_i    = toggle ? cyc[0] : 1'b1;
      driveMshr(capNext, needRsp, prefetch, word);
      #1;
      capNext = mshr_ack_o & mshr_ack_gnt_i;
      if (mshr_ack_o) begin
        ackSeen++;
        ackCycles++;
        if (mshr_ack_set_o !== 3'd5 || mshr_ack_way_o !== 2'd1) ackAddrBad++;
        if (mem_rsp_ready_o) badReady++;
      end
      if (mem_rsp_valid_i && mem_rsp_ready_o) begin
        if (refill_write_o) begin
          writes++;
          if (refill_beat_o !== 2'(b) || refill_data_o !== beatData ||
              refill_set_o !== 7'h2A || refill_way_o !== 2'd3) seqBad++;
        end
        if (refill_done_o) begin
          dones++;
          if (refill_tag_o !== 20'hABCDE || refill_wback_o !== 1'b1) tagBad++;
        end
        b++;
      end
      if (core_rsp_valid_o) begin
        rspCount++;
        rspErr  = core_rsp_error_o;
        rspData = core_rsp_data_o;
        rspIds  = {core_rsp_req_id_o, core_rsp_src_id_o};
      end
      if (b >= 4) post++;
      if (post == 4 || b == abortAt) finished = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    mem_rsp_valid_i = 1'b0;
    checkOutput("line_finished", finished, 1'b1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput(tag, {mem_rsp_ready_o, mshr_ack_o, refill_write_o, refill_done_o,
                      core_rsp_valid_o, core_rsp_error_o, refill_tag_o, refill_beat_o,
                      mshr_ack_set_o, refill_wback_o}, '0);
    checkOutput({tag, "_data"}, refill_data_o, '0);
  endtask

  initial begin
    rst = 1'b1;
    mem_rsp_valid_i = 1'b0; mem_rsp_id_i = '0; mem_rsp_data_i = '0;
    mem_rsp_error_i = 1'b0; mem_rsp_last_i = 1'b0; mshr_ack_gnt_i = 1'b0;
    refill_ready_i = 1'b1; core_rsp_ready_i = 1'b1;
    driveMshr(1'b0, 1'b0, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b0;

    // Clean line, immediate grant, word 5 -> beat 2 word 1 = 0x21.
    applyStimulus(0, 1'b0, -1, -1, 1'b1, 1'b0, 3'd5);
    checkOutput("t1_acks", ackCycles, 1);
    checkOutput("t1_ackaddr", ackAddrBad, 0);
    checkOutput("t1_writes", writes, 4);
    checkOutput("t1_seq", seqBad, 0);
    checkOutput("t1_done", dones, 1);
    checkOutput("t1_tag", tagBad, 0);
    checkOutput("t1_rsp", rspCount, 1);
    checkOutput("t1_rspdata", rspData, 64'h21);
    checkOutput("t1_rsperr", rspErr, 1'b0);
    checkOutput("t1_rspids", rspIds, {8'h5A, 3'd6});

    // Grant withheld 3 cycles, word 3 -> beat 1 word 1 = 0x11.
    applyStimulus(3, 1'b0, -1, -1, 1'b1, 1'b0, 3'd3);
    checkOutput("t2_acks", ackCycles, 4);
    checkOutput("t2_ackaddr", ackAddrBad, 0);
    checkOutput("t2_ready_in_ack", badReady, 0);
    checkOutput("t2_writes", writes, 4);
    checkOutput("t2_rspdata", rspData, 64'h11);

    // Back-pressure on the data array, word 6 -> beat 3 word 0 = 0x30.
    applyStimulus(0, 1'b1, -1, -1, 1'b1, 1'b0, 3'd6);
    checkOutput("t3_writes", writes, 4);
    checkOutput("t3_seq", seqBad, 0);
    checkOutput("t3_done", dones, 1);
    checkOutput("t3_rspdata", rspData, 64'h30);

    // Error on beat 1: only beat 0 written, no done, error response.
    applyStimulus(0, 1'b0, 1, -1, 1'b1, 1'b0, 3'd0);
    checkOutput("t4_writes", writes, 1);
    checkOutput("t4_seq", seqBad, 0);
    checkOutput("t4_done", dones, 0);
    checkOutput("t4_rsp", rspCount, 1);
    checkOutput("t4_rsperr", rspErr, 1'b1);

    // Prefetch: full refill, no core response.
    applyStimulus(0, 1'b0, -1, -1, 1'b1, 1'b1, 3'd2);
    checkOutput("t5_writes", writes, 4);
    checkOutput("t5_done", dones, 1);
    checkOutput("t5_rsp", rspCount, 0);

    // Reset after two beats, then a clean line with word 1 -> 0x01.
    applyStimulus(0, 1'b0, -1, 2, 1'b1, 1'b0, 3'd4);
    checkOutput("t6_pre_writes", writes, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkIdleOutputs("t6_reset");
    rst = 1'b0;
    applyStimulus(0, 1'b0, -1, -1, 1'b1, 1'b0, 3'd1);
    checkOutput("t6_writes", writes, 4);
    checkOutput("t6_done", dones, 1);
    checkOutput("t6_rspdata", rspData, 64'h01);
    checkOutput("t6_rsperr", rspErr, 1'b0);

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
